res_tx: RTL
===========

# res_tx

Serial transmitter that drains the result FIFO (`res_fifo`) and sends each 16-bit result to the host over a single UART-style line. It sits on the read side of the result FIFO: it pops one entry whenever the FIFO is non-empty and transmission is enabled, then sends the low byte and then the high byte. Each byte is framed with one start bit, eight data bits sent LSB first, and one stop bit. Line rate is set by a clocks-per-bit parameter.

## Interface
- `BIT_PERIOD`, default 10: clock cycles per serial bit; legal range 2–1023.
- `clk` in 1: system clock; all state changes on the rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `tx_enable` in 1: allows a new FIFO pop when high; it does not interrupt a frame already in progress.
- `fifo_empty` in 1: `empty` flag from `res_fifo`.
- `fifo_result` in 16: `result_out` from `res_fifo`; valid the cycle after a `fifo_renable` pulse.
- `fifo_renable` out 1: one-cycle pop strobe to `res_fifo`.
- `serial_out` out 1: serial line; idle and stop level is 1.
- `busy` out 1: high from READ through the final STOP bit.
- `tx_done` out 1: one-cycle pulse after the high byte's stop bit completes.

## Operation
- **States:** IDLE, READ, LOAD, START, DATA, STOP.
- **IDLE:**
  - Go to READ when `!fifo_empty && tx_enable`.
  - Otherwise stay in IDLE.
- **READ:**
  - `fifo_renable`=1 for exactly this cycle.
  - Always go to LOAD next.
- **LOAD:**
  - Capture `fifo_result` into a 16-bit holding register.
  - Clear `byte_sel` (0 selects the low byte).
  - Go to START.
- **START:**
  - `serial_out`=0 for BIT_PERIOD cycles.
  - Load the 8-bit shift register with the byte selected by `byte_sel`.
  - Go to DATA.
- **DATA:**
  - `serial_out` = shift[0] for BIT_PERIOD cycles per bit.
  - Shift right at the end of each bit period.
  - Go to STOP after 8 bits.
- **STOP:**
  - `serial_out`=1 for BIT_PERIOD cycles.
  - At the end of the period: if `byte_sel`=0, set `byte_sel`=1 and go to START.
  - Otherwise pulse `tx_done` and go to IDLE.
- **Outputs:** Moore outputs, decoded only from registered state, bit counter and shift register; no combinational paths from inputs to outputs.
- **Bit timer:**
  - Counts 1..BIT_PERIOD and asserts rollover on the last cycle of each bit.
  - Cleared on every state transition.
- **Bit index:** 3-bit counter of data bits sent; wraps 7→0 when leaving DATA.
- **Boundary conditions:**
  - `tx_enable` falls mid-frame: both bytes complete; the next pop is blocked.
  - `fifo_empty` rises mid-frame: ignored until IDLE.
  - FIFO never popped while `fifo_empty`=1; READ is only entered from IDLE with the empty flag low.
  - Back-to-back entries: the line stays high for 1 IDLE + 1 READ + 1 LOAD cycle between frames.
  - `n_rst` low mid-frame: immediate return to IDLE with the line high. The popped result is discarded and not re-sent.

## Timing
- **Reset values:**
  - `serial_out`=1, `fifo_renable`=0, `busy`=0, `tx_done`=0.
  - State IDLE; holding and shift registers cleared to 0.
- **Start latency:** `fifo_empty` is sampled low in IDLE at edge k.
  - Cycle after edge k: READ, with `fifo_renable` high.
  - Cycle after edge k+1: LOAD.
  - Cycle after edge k+2: start bit on `serial_out`.
- **Frame length:** one result occupies 20·BIT_PERIOD cycles on the line.
- **`tx_done`:** high for the single cycle following the last stop-bit cycle, which is also the first IDLE cycle.
- **`busy`:** rises with READ; falls with the `tx_done` cycle.

## Structure
- **Package `res_tx_pkg`:**
  - State enum `res_tx_state_t`.
  - `RESULT_W`=16, `DATA_BITS`=8, `FRAME_BITS`=10.
- **Sub-module `res_tx_timer`:**
  - Parameterized rollover counter with clear and count-enable inputs and a rollover flag.
  - Used for the bit period.
- **Top:** FSM, holding register, shift register and bit index live in `res_tx`.

## Test plan
All scenarios use BIT_PERIOD=4.
- **Reset:** `n_rst`=0 -> `serial_out`=1, `fifo_renable`=0, `busy`=0, `tx_done`=0. With `fifo_empty`=1 after release, the line stays 1 for 50 cycles.
- **Single result 16'd68 (0x0044):**
  - `fifo_renable` pulses exactly once, 1 cycle after empty falls.
  - Line carries 0,0,0,1,0,0,0,1,0,1 then 0,0,0,0,0,0,0,0,0,1, each bit 4 cycles.
  - `tx_done` pulses once, 80 cycles after the start bit begins.
- **Back-to-back 68 then 2021 (0x07E5):**
  - Exactly 2 pops.
  - Second frame's start bit begins 3 cycles after the first `tx_done` cycle.
  - Bytes on the line: 0x44, 0x00, 0xE5, 0x07.
- **Enable gating:**
  - `tx_enable`=0 with a non-empty FIFO -> no pop for 40 cycles.
  - Dropping `tx_enable` mid-frame -> current result completes and no further pop occurs.
- **Reset mid-frame:** `n_rst` pulsed low during DATA of 0x07E5 -> line goes 1 immediately and `busy`=0. After release with the FIFO non-empty, the next entry is popped, not the lost one.
- **Empty rises mid-frame:** `fifo_empty` rises during the low byte -> frame completes, `tx_done` pulses, FSM stays in IDLE and `fifo_renable` stays 0.

Source files
------------

// File: rtl/res_tx_pkg.sv
// Shared types and widths for the result-FIFO serial transmitter.
package res_tx_pkg;
  localparam int RESULT_W   = 16;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } res_tx_state_t;
endpackage

// File: rtl/res_tx_timer.sv
// Bit-period counter: runs 1..PERIOD and flags the last cycle of each period.
module res_tx_timer #(
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_roll
);
  localparam int CW = $clog2(PERIOD + 1);

  logic [CW-1:0] r_cnt;

  assign o_roll = (r_cnt == CW'(PERIOD));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       r_cnt <= CW'(1);
    else if (i_clear) r_cnt <= CW'(1);
    else if (i_en)    r_cnt <= o_roll ? CW'(1) : r_cnt + 1'b1;
  end
endmodule

// File: rtl/res_tx.sv
// Pops 16-bit results from res_fifo and sends them low byte first as
// two 8N1 frames on a single serial line.
module res_tx
  import res_tx_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tx_enable,
  input  logic                fifo_empty,
  input  logic [RESULT_W-1:0] fifo_result,
  output logic                fifo_renable,
  output logic                serial_out,
  output logic                busy,
  output logic                tx_done
);
  localparam int IDX_W = $clog2(DATA_BITS);

  res_tx_state_t        r_state;
  logic [RESULT_W-1:0]  r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_byte_sel;
  logic                 r_tx_done;
  logic                 w_roll;
  logic                 w_leave;
  logic                 w_tmr_en;

  // w_leave is high exactly on cycles where the FSM changes state; it also
  // restarts the bit timer so every state begins on a fresh bit period.
  always_comb begin
    w_leave = 1'b0;
    case (r_state)
      S_IDLE:          w_leave = !fifo_empty && tx_enable;
      S_READ, S_LOAD:  w_leave = 1'b1;
      S_START, S_STOP: w_leave = w_roll;
      S_DATA:          w_leave = w_roll && (r_bit_idx == IDX_W'(DATA_BITS - 1));
      default:         w_leave = 1'b1;
    endcase
  end

  assign w_tmr_en = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

  res_tx_timer #(.PERIOD(BIT_PERIOD)) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clear(w_leave),
    .i_en   (w_tmr_en),
    .o_roll (w_roll)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_leave) r_state <= S_READ;
        S_READ: r_state <= S_LOAD;
        S_LOAD: begin
          r_hold     <= fifo_result;
          r_byte_sel <= 1'b0;
          r_state    <= S_START;
        end
        S_START: if (w_roll) begin
          r_shift <= r_byte_sel ? r_hold[RESULT_W-1:DATA_BITS] : r_hold[DATA_BITS-1:0];
          r_state <= S_DATA;
        end
        S_DATA: if (w_roll) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 1'b1;
          if (w_leave) r_state <= S_STOP;
        end
        S_STOP: if (w_roll) begin
          if (!r_byte_sel) begin
            r_byte_sel <= 1'b1;
            r_state    <= S_START;
          end else begin
            r_tx_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_renable = (r_state == S_READ);
  assign busy         = (r_state != S_IDLE);
  assign tx_done      = r_tx_done;

  always_comb begin
    serial_out = 1'b1;
    case (r_state)
      S_START: serial_out = 1'b0;
      S_DATA:  serial_out = r_shift[0];
      default: serial_out = 1'b1;
    endcase
  end
endmodule
